adc_scan_sequencer: RTL and testbench
=====================================

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 SHALL have parameters: N_CH, default 4, number of ADC channels (1..16); DATA_W, default 8, ADC sample width; FIFO_DEPTH, default 8, result FIFO entries (power of 2, >=2); CH_W = max(1, clog2(N_CH)), derived.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, the divided ADC clock.
- resn  in  1  asynchronous active-low reset.
- cfg_ch_mask  in  N_CH  channel enable, bit i = channel i.
- cfg_continuous  in  1  1 = repeat scans, 0 = single scan.
- cfg_scan_gap  in  16  idle cycles between continuous scans.
- start  in  1  start request, level, sampled in IDLE.
- stop  in  1  stop request, level.
- clr_overflow  in  1  clears the overflow flag.
- adc_ch_sel  out  CH_W  channel under conversion.
- adc_start  out  1  conversion request to the ADC.
- adc_busy  in  1  ADC conversion in progress.
- adc_valid  in  1  one-cycle result strobe.
- adc_value  in  DATA_W  conversion result.
- m_tdata  out  CH_W+DATA_W  {channel, sample}.
- m_tvalid  out  1  FIFO not empty.
- m_tready  in  1  consumer accepts the head entry.
- busy  out  1  scan active (state not IDLE).
- overflow  out  1  sticky result-drop flag.
- fifo_level  out  clog2(FIFO_DEPTH)+1  occupied FIFO entries.
REQ-003 SHALL use one clock, clk, with asynchronous active-low reset resn; all flops are clocked by clk.

Function
REQ-004 SHALL use states IDLE, SELECT, CONVERT, WAIT_RESULT, NEXT and GAP.
REQ-005 IDLE: if start=1 and cfg_ch_mask!=0, SHALL snapshot the mask, load the lowest enabled channel and go to SELECT next cycle; start with an all-zero mask SHALL be ignored.
REQ-006 SELECT SHALL drive adc_ch_sel for one cycle with adc_start=0, then go to CONVERT.
REQ-007 CONVERT SHALL hold adc_start=1 until adc_busy=1 is sampled, then drop adc_start the next cycle and enter WAIT_RESULT.
REQ-008 WAIT_RESULT SHALL wait for adc_valid=1 and push {adc_ch_sel, adc_value} into the FIFO in that same cycle, then go to NEXT.
REQ-009 adc_ch_sel SHALL remain stable from SELECT through WAIT_RESULT.
REQ-010 NEXT SHALL advance to the next higher enabled channel in the snapshot (go to SELECT).
- After the last enabled channel: single mode goes to IDLE; continuous mode goes to GAP.
REQ-011 GAP SHALL count cfg_scan_gap cycles (0 = leave immediately), re-snapshot cfg_ch_mask and go to SELECT.
- If the new mask is 0, go to IDLE.
REQ-012 stop=1 SHALL be honoured only in NEXT or GAP (go to IDLE); a conversion already in progress always completes and its result is pushed.
REQ-013 FIFO push SHALL be accepted when fifo_level<FIFO_DEPTH, or when a pop occurs in the same cycle; otherwise the sample is dropped and overflow is set.
REQ-014 Pop occurs on m_tvalid && m_tready; m_tdata SHALL present the head entry combinationally from storage.
REQ-015 Simultaneous push and pop SHALL leave fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-016 overflow SHALL stay set until clr_overflow=1; if a drop and clr_overflow occur in the same cycle, overflow SHALL be 1.
REQ-017 Push latency: an entry written on cycle t SHALL be visible on m_tvalid at t+1.

Reset
REQ-018 While resn=0: state=IDLE, adc_start=0, adc_ch_sel=0, busy=0, overflow=0, FIFO empty (m_tvalid=0, fifo_level=0), gap counter=0.
REQ-019 Reset asserted mid-scan SHALL abort immediately; FIFO contents are discarded.

Configuration
REQ-020 Macro ADC_SCAN_AVG_EN defined: SHALL add input cfg_avg_log2 [2:0]; each channel is converted 2^cfg_avg_log2 times (CONVERT/WAIT_RESULT repeated), summed in a DATA_W+7-bit accumulator cleared at SELECT, and a single result (sum >> cfg_avg_log2, truncated) is pushed after the last sample.
REQ-021 Macro ADC_SCAN_AVG_EN undefined: no cfg_avg_log2 port; exactly one conversion per channel, raw adc_value pushed.

Verification
REQ-022 Single scan, N_CH=4, mask=4'b1010, ADC model returns 8'h11*ch -> FIFO holds {1,8'h11},{3,8'h33}; busy then returns to 0.
REQ-023 Continuous scan, mask=4'b0001, gap=5, stop raised mid-GAP -> ADC restarts exactly 5 cycles after NEXT; stop -> IDLE with no further adc_start.
REQ-024 m_tready=0, FIFO_DEPTH=8, 9 results -> fifo_level=8, overflow=1, 9th sample lost; clr_overflow -> overflow=0.
REQ-025 FIFO full while adc_valid and m_tready=1 in same cycle -> push accepted, level stays 8, overflow stays 0.
REQ-026 resn pulsed low during WAIT_RESULT -> adc_start=0, busy=0, m_tvalid=0 asynchronously; start with mask=0 -> stays IDLE.
REQ-027 ADC_SCAN_AVG_EN defined, cfg_avg_log2=2, samples 10,11,12,13 -> one entry with value 11.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer
//
// Walks the enabled channels of a multiplexed ADC in ascending order, issues
// a conversion per channel with a start/busy/valid handshake, and queues the
// results as {channel, sample} words in a small FIFO for a ready/valid
// consumer. It supports single-scan and continuous-scan modes, with a
// programmable idle gap between continuous scans.
//
// Optional build macro: ADC_SCAN_AVG_EN
//   When defined, each channel is converted 2^cfg_avg_log2 times. The samples
//   are summed and one averaged result is pushed per channel.
//
// Parameters
//   N_CH        number of ADC channels (1..16)
//   DATA_W      ADC sample width
//   FIFO_DEPTH  result FIFO entries (power of two, >= 2)
//   CH_W        derived channel index width, max(1, clog2(N_CH))
//
// Ports
//   clk              divided ADC clock; the only clock
//   resn             asynchronous active-low reset
//   cfg_ch_mask      channel enables, bit i = channel i
//   cfg_continuous   1 = repeat scans, 0 = single scan
//   cfg_scan_gap     idle cycles between continuous scans
//   cfg_avg_log2     (ADC_SCAN_AVG_EN only) log2 of samples per channel
//   start            start request (level), sampled in IDLE
//   stop             stop request (level), honoured between conversions
//   clr_overflow     clears the sticky overflow flag
//   adc_ch_sel       channel under conversion
//   adc_start        conversion request, held until adc_busy is seen
//   adc_busy         ADC conversion in progress
//   adc_valid        one-cycle result strobe
//   adc_value        conversion result
//   m_tdata          FIFO head {channel, sample}
//   m_tvalid         FIFO not empty
//   m_tready         consumer accepts the head entry
//   busy             scan active (state not IDLE)
//   overflow         sticky flag: a result was dropped because the FIFO was full
//   fifo_level       occupied FIFO entries
// ---------------------------------------------------------------------------
module adc_scan_sequencer #(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     resn,
  input  logic [N_CH-1:0]          cfg_ch_mask,
  input  logic                     cfg_continuous,
  input  logic [15:0]              cfg_scan_gap,
`ifdef ADC_SCAN_AVG_EN
  input  logic [2:0]               cfg_avg_log2,
`endif
  input  logic                     start,
  input  logic                     stop,
  input  logic                     clr_overflow,
  output logic [CH_W-1:0]          adc_ch_sel,
  output logic                     adc_start,
  input  logic                     adc_busy,
  input  logic                     adc_valid,
  input  logic [DATA_W-1:0]        adc_value,
  output logic [CH_W+DATA_W-1:0]   m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     busy,
  output logic                     overflow,
  output logic [LVL_W-1:0]         fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CONVERT,
    WAIT_RESULT,
    NEXT,
    GAP
  } state_t;

  state_t            state_reg, state_next;
  logic [N_CH-1:0]   mask_reg, mask_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic [15:0]       gap_cnt_reg, gap_cnt_next;

  logic              push_req;
  logic              last_sample;
  logic [DATA_W-1:0] push_value;

  // Index of the lowest set bit; zero for an empty vector.
  function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // Enabled channels above the current one in the scan snapshot.
  logic [N_CH-1:0] higher_mask;
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_higher
    assign higher_mask[gi] = mask_reg[gi] && (CH_W'(gi) > ch_reg);
  end

`ifdef ADC_SCAN_AVG_EN
  // The accumulator is sized for up to 128 full-scale samples.
  logic [DATA_W+6:0] acc_reg, acc_next, acc_sum;
  logic [7:0]        avg_cnt_reg, avg_cnt_next;
  logic [7:0]        avg_target;

  assign acc_sum     = acc_reg + (DATA_W+7)'(adc_value);
  assign avg_target  = 8'd1 << cfg_avg_log2;
  assign last_sample = ((avg_cnt_reg + 8'd1) == avg_target);
  assign push_value  = DATA_W'(acc_sum >> cfg_avg_log2);

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      acc_reg     <= '0;
      avg_cnt_reg <= '0;
    end else begin
      acc_reg     <= acc_next;
      avg_cnt_reg <= avg_cnt_next;
    end
  end
`else
  assign last_sample = 1'b1;
  assign push_value  = adc_value;
`endif

  // -------------------------------------------------------------------------
  // Scan FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_reg   <= IDLE;
      mask_reg    <= '0;
      ch_reg      <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      ch_reg      <= ch_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mask_next    = mask_reg;
    ch_next      = ch_reg;
    gap_cnt_next = gap_cnt_reg;
    push_req     = 1'b0;
`ifdef ADC_SCAN_AVG_EN
    acc_next     = acc_reg;
    avg_cnt_next = avg_cnt_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (start && (|cfg_ch_mask)) begin
          mask_next  = cfg_ch_mask;
          ch_next    = lowest_set(cfg_ch_mask);
          state_next = SELECT;
        end
      end
      SELECT: begin
`ifdef ADC_SCAN_AVG_EN
        acc_next     = '0;
        avg_cnt_next = '0;
`endif
        state_next = CONVERT;
      end
      CONVERT: begin
        // adc_start is decoded from this state, so it drops on the cycle
        // after busy is seen.
        if (adc_busy) state_next = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (adc_valid) begin
`ifdef ADC_SCAN_AVG_EN
          acc_next     = acc_sum;
          avg_cnt_next = avg_cnt_reg + 8'd1;
`endif
          if (last_sample) begin
            push_req   = 1'b1;
            state_next = NEXT;
          end else begin
            state_next = CONVERT;
          end
        end
      end
      NEXT: begin
        if (stop) begin
          state_next = IDLE;
        end else if (|higher_mask) begin
          ch_next    = lowest_set(higher_mask);
          state_next = SELECT;
        end else if (cfg_continuous) begin
          gap_cnt_next = cfg_scan_gap;
          state_next   = GAP;
        end else begin
          state_next = IDLE;
        end
      end
      GAP: begin
        // GAP lasts cfg_scan_gap cycles. A gap of 0 or 1 occupies a single
        // cycle, the minimum needed to re-snapshot the mask.
        if (stop) begin
          gap_cnt_next = '0;
          state_next   = IDLE;
        end else if (gap_cnt_reg <= 16'd1) begin
          gap_cnt_next = '0;
          if (|cfg_ch_mask) begin
            mask_next  = cfg_ch_mask;
            ch_next    = lowest_set(cfg_ch_mask);
            state_next = SELECT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign adc_start  = (state_reg == CONVERT);
  assign adc_ch_sel = ch_reg;
  assign busy       = (state_reg != IDLE);

  // -------------------------------------------------------------------------
  // Result FIFO: the head is read combinationally from storage.
  // -------------------------------------------------------------------------
  logic [CH_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]       level_reg;
  logic                   overflow_reg;
  logic                   pop, push_ok, drop, fifo_full;

  assign m_tvalid  = (level_reg != '0);
  assign pop       = m_tvalid && m_tready;
  assign fifo_full = (level_reg == LVL_W'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push_req && (!fifo_full || pop);
  assign drop      = push_req && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= {ch_reg, push_value};
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop)      level_reg <= level_reg + LVL_W'(1);
      else if (pop && !push_ok) level_reg <= level_reg - LVL_W'(1);
      // A drop wins over a simultaneous clear.
      if (drop)              overflow_reg <= 1'b1;
      else if (clr_overflow) overflow_reg <= 1'b0;
    end
  end

  assign m_tdata    = fifo_mem[rd_ptr_reg];
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_scan_sequencer
//
// Directed bench for adc_scan_sequencer (N_CH=4, DATA_W=8, FIFO_DEPTH=8).
// A behavioural ADC answers each adc_start with two busy cycles and then a
// valid strobe carrying 8'h11*channel, unless a value is queued in val_q.
// Expected FIFO words are queued in exp_q as the stimulus is driven and are
// compared as the consumer drains the FIFO.
// ---------------------------------------------------------------------------
module tb_adc_scan_sequencer;

  localparam int N_CH       = 4;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int CH_W       = 2;
  localparam int LVL_W      = 4;

  logic                   clk;
  logic                   resn;
  logic [N_CH-1:0]        cfg_ch_mask;
  logic                   cfg_continuous;
  logic [15:0]            cfg_scan_gap;
`ifdef ADC_SCAN_AVG_EN
  logic [2:0]             cfg_avg_log2;
`endif
  logic                   start;
  logic                   stop;
  logic                   clr_overflow;
  logic [CH_W-1:0]        adc_ch_sel;
  logic                   adc_start;
  logic                   adc_busy;
  logic                   adc_valid;
  logic [DATA_W-1:0]      adc_value;
  logic [CH_W+DATA_W-1:0] m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   busy;
  logic                   overflow;
  logic [LVL_W-1:0]       fifo_level;

  logic [CH_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0]      val_q[$];
  int errors = 0;
  int checks = 0;

  adc_scan_sequencer #(
    .N_CH(N_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .resn(resn),
    .cfg_ch_mask(cfg_ch_mask),
    .cfg_continuous(cfg_continuous),
    .cfg_scan_gap(cfg_scan_gap),
`ifdef ADC_SCAN_AVG_EN
    .cfg_avg_log2(cfg_avg_log2),
`endif
    .start(start),
    .stop(stop),
    .clr_overflow(clr_overflow),
    .adc_ch_sel(adc_ch_sel),
    .adc_start(adc_start),
    .adc_busy(adc_busy),
    .adc_valid(adc_valid),
    .adc_value(adc_value),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .busy(busy),
    .overflow(overflow),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ADC, acting on falling edges.
  int adc_cnt = 0;
  int adc_ch_lat = 0;
  initial begin
    adc_busy  = 1'b0;
    adc_valid = 1'b0;
    adc_value = '0;
    forever begin
      @(negedge clk);
      adc_valid = 1'b0;
      if (adc_cnt > 0) begin
        adc_cnt = adc_cnt - 1;
        if (adc_cnt == 0) begin
          adc_busy  = 1'b0;
          adc_valid = 1'b1;
          if (val_q.size() > 0) adc_value = val_q.pop_front();
          else                  adc_value = 8'(8'h11 * adc_ch_lat);
        end
      end else if (adc_start && !adc_busy) begin
        adc_busy   = 1'b1;
        adc_ch_lat = int'(adc_ch_sel);
        adc_cnt    = 2;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [CH_W+DATA_W-1:0] ent(input int ch, input int val);
    return {CH_W'(ch), DATA_W'(val)};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (adc_valid !== 1'b1 && n < 200);
    chk({tag, "_valid_seen"}, 32'(adc_valid), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    m_tready = 1'b1;
    while (exp_q.size() > 0 && guard < 64) begin
      if (m_tvalid) begin
        $display("txn %s pop m_tdata=%h", tag, m_tdata);
        chk({tag, "_data"}, 32'(m_tdata), 32'(exp_q.pop_front()));
      end
      step();
      guard++;
    end
    m_tready = 1'b0;
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_empty"}, 32'(m_tvalid), 32'd0);
  endtask

  initial begin
    int n;
    resn           = 1'b1;
    cfg_ch_mask    = '0;
    cfg_continuous = 1'b0;
    cfg_scan_gap   = '0;
`ifdef ADC_SCAN_AVG_EN
    cfg_avg_log2   = '0;
`endif
    start          = 1'b0;
    stop           = 1'b0;
    clr_overflow   = 1'b0;
    m_tready       = 1'b0;

    // Reset state
    #1 resn = 1'b0;
    #2;
    chk("rst_adc_start", 32'(adc_start), 32'd0);
    chk("rst_ch_sel", 32'(adc_ch_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    repeat (2) step();
    resn = 1'b1;
    step();

    // Single scan over channels 1 and 3
    cfg_ch_mask = 4'b1010;
    exp_q.push_back(ent(1, 8'h11));
    exp_q.push_back(ent(3, 8'h33));
    pulse_start();
    chk("single_busy", 32'(busy), 32'd1);
    wait_valid("single_first");
    chk("single_ch_sel", 32'(adc_ch_sel), 32'd1);
    step();
    chk("single_push_latency", 32'(m_tvalid), 32'd1);
    wait_idle("single");
    chk("single_level", 32'(fifo_level), 32'd2);
    drain("single");

    // Continuous scan of channel 0, gap 5, stop inside GAP
    cfg_ch_mask    = 4'b0001;
    cfg_continuous = 1'b1;
    cfg_scan_gap   = 16'd5;
    exp_q.push_back(ent(0, 0));
    exp_q.push_back(ent(0, 0));
    pulse_start();
    wait_valid("cont_first");
    // NEXT, five GAP cycles and SELECT precede the next request.
    n = 0;
    do begin
      step();
      n++;
    end while (adc_start !== 1'b1 && n < 40);
    chk("cont_gap_cycles", 32'(n), 32'd8);
    wait_valid("cont_second");
    repeat (3) step();
    stop = 1'b1;
    step();
    chk("cont_stop_idle", 32'(busy), 32'd0);
    stop           = 1'b0;
    cfg_continuous = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (adc_start) n++;
      step();
    end
    chk("cont_no_restart", 32'(n), 32'd0);
    drain("cont");

    // Overflow: nine results into an eight-entry FIFO with no consumer
    cfg_ch_mask    = 4'b1111;
    cfg_continuous = 1'b1;
    cfg_scan_gap   = 16'd0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) exp_q.push_back(ent(c, 8'h11 * c));
    pulse_start();
    for (int i = 0; i < 9; i++) wait_valid("ovf");
    chk("ovf_before_drop", 32'(overflow), 32'd0);
    stop = 1'b1;
    repeat (3) step();
    stop           = 1'b0;
    cfg_continuous = 1'b0;
    chk("ovf_idle", 32'(busy), 32'd0);
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Full FIFO: push and pop in the same cycle
    cfg_ch_mask = 4'b0100;
    pulse_start();
    wait_valid("full_pushpop");
    chk("full_head", 32'(m_tdata), 32'(exp_q.pop_front()));
    exp_q.push_back(ent(2, 8'h22));
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_no_overflow", 32'(overflow), 32'd0);
    wait_idle("full");
    drain("full");

    // Reset during WAIT_RESULT
    cfg_ch_mask = 4'b0011;
    pulse_start();
    wait_valid("rst_mid");
    n = 0;
    while (adc_busy !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    step();
    resn = 1'b0;
    #1;
    chk("rst_mid_adc_start", 32'(adc_start), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_mid_level", 32'(fifo_level), 32'd0);
    step();
    resn = 1'b1;
    repeat (5) step();

    // Start with an empty mask is ignored
    cfg_ch_mask = 4'b0000;
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    chk("zero_mask_busy", 32'(busy), 32'd0);
    chk("zero_mask_adc_start", 32'(adc_start), 32'd0);
    chk("zero_mask_tvalid", 32'(m_tvalid), 32'd0);

`ifdef ADC_SCAN_AVG_EN
    // Four-sample average of 10, 11, 12, 13 -> 11
    cfg_avg_log2 = 3'd2;
    cfg_ch_mask  = 4'b0001;
    val_q.push_back(8'd10);
    val_q.push_back(8'd11);
    val_q.push_back(8'd12);
    val_q.push_back(8'd13);
    exp_q.push_back(ent(0, 11));
    pulse_start();
    wait_idle("avg");
    chk("avg_level", 32'(fifo_level), 32'd1);
    drain("avg");
    cfg_avg_log2 = 3'd0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
